// File: rtl/ghost_motion_commit_if.sv
// Steering bus between the ghost controller (master) and the motion commit block (slave).
interface ghost_motion_commit_if #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned COLS   = 32,
  parameter int unsigned ROWS   = 24
);
  localparam int unsigned X_W = $clog2(WIDTH);
  localparam int unsigned Y_W = $clog2(HEIGHT);
  localparam int unsigned N_T = ROWS * COLS;

  logic           freeze;
  logic [X_W-1:0] next_x;
  logic [Y_W-1:0] next_y;
  logic [1:0]     ghost_direction;
  logic [N_T-1:0] tilemap_walls;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [1:0]     committed_dir;
  logic           move_done;
  logic           blocked;
  logic [7:0]     tick_count;

  modport master (
    output freeze, next_x, next_y, ghost_direction, tilemap_walls,
    input  x, y, committed_dir, move_done, blocked, tick_count
  );

  modport slave (
    input  freeze, next_x, next_y, ghost_direction, tilemap_walls,
    output x, y, committed_dir, move_done, blocked, tick_count
  );
endinterface

// File: rtl/ghost_motion_commit.sv
// Paces ghost movement with a tick divider, checks the proposed tile against the
// wall map and commits or rejects the move; x/y are fed back to controller and renderer.
module ghost_motion_commit #(
  parameter int unsigned TICK_DIV  = 8,
  parameter int unsigned TILE_SIZE = 20,
  parameter int unsigned WIDTH     = 640,
  parameter int unsigned HEIGHT    = 480,
  parameter int unsigned COLS      = 32,
  parameter int unsigned ROWS      = 24,
  parameter int unsigned SPAWN_X   = 300,
  parameter int unsigned SPAWN_Y   = 200
) (
  input logic                  clk,
  input logic                  reset,
  ghost_motion_commit_if.slave bus
);
  localparam int unsigned X_W   = $clog2(WIDTH);
  localparam int unsigned Y_W   = $clog2(HEIGHT);
  localparam int unsigned IDX_W = $clog2(ROWS * COLS);
  localparam int unsigned DIV_W = $clog2(TICK_DIV);

  localparam logic [1:0] DIR_LEFT = 2'd2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SAMPLE = 2'd1;
  localparam logic [1:0] S_LOOKUP = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [X_W-1:0]   req_x_q, req_x_d;
  logic [Y_W-1:0]   req_y_q, req_y_d;
  logic [1:0]       req_dir_q, req_dir_d;
  logic             bad_q, bad_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [1:0]       dir_q, dir_d;
  logic             move_done_q, move_done_d;
  logic             blocked_q, blocked_d;
  logic [7:0]       tick_count_q, tick_count_d;

  logic             tick_c;
  logic [X_W-1:0]   col_c;
  logic [Y_W-1:0]   row_c;
  logic [IDX_W-1:0] idx_c;
  logic             oor_c;
  logic             wall_c;

  assign tick_c = !bus.freeze && (div_q == DIV_W'(TICK_DIV - 1));

  // Tile lookup; an out-of-range request (including x underflow wrap) never indexes the map.
  assign col_c  = req_x_q / X_W'(TILE_SIZE);
  assign row_c  = req_y_q / Y_W'(TILE_SIZE);
  assign idx_c  = IDX_W'(row_c) * IDX_W'(COLS) + IDX_W'(col_c);
  assign oor_c  = (req_x_q >= X_W'(WIDTH)) || (req_y_q >= Y_W'(HEIGHT));
  assign wall_c = !oor_c && bus.tilemap_walls[idx_c];

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    req_x_d      = req_x_q;
    req_y_d      = req_y_q;
    req_dir_d    = req_dir_q;
    bad_d        = bad_q;
    x_d          = x_q;
    y_d          = y_q;
    dir_d        = dir_q;
    move_done_d  = 1'b0;
    blocked_d    = blocked_q;
    tick_count_d = tick_count_q;

    if (!bus.freeze) begin
      div_d = tick_c ? '0 : div_q + DIV_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tick_c) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        req_x_d   = bus.next_x;
        req_y_d   = bus.next_y;
        req_dir_d = bus.ghost_direction;
        state_d   = S_LOOKUP;
      end
      S_LOOKUP: begin
        bad_d   = oor_c || wall_c;
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        move_done_d = 1'b1;
        if (!bad_q) begin
          x_d          = req_x_q;
          y_d          = req_y_q;
          dir_d        = req_dir_q;
          tick_count_d = tick_count_q + 8'd1;
          blocked_d    = 1'b0;
        end else begin
          blocked_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      req_x_q      <= '0;
      req_y_q      <= '0;
      req_dir_q    <= DIR_LEFT;
      bad_q        <= 1'b0;
      x_q          <= X_W'(SPAWN_X);
      y_q          <= Y_W'(SPAWN_Y);
      dir_q        <= DIR_LEFT;
      move_done_q  <= 1'b0;
      blocked_q    <= 1'b0;
      tick_count_q <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      req_x_q      <= req_x_d;
      req_y_q      <= req_y_d;
      req_dir_q    <= req_dir_d;
      bad_q        <= bad_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_q        <= dir_d;
      move_done_q  <= move_done_d;
      blocked_q    <= blocked_d;
      tick_count_q <= tick_count_d;
    end
  end

  assign bus.x             = x_q;
  assign bus.y             = y_q;
  assign bus.committed_dir = dir_q;
  assign bus.move_done     = move_done_q;
  assign bus.blocked       = blocked_q;
  assign bus.tick_count    = tick_count_q;
endmodule

// File: tb/tb_ghost_motion_commit.sv
// Scoreboard bench for ghost_motion_commit: directed proposals, per-cycle move_done timing check.
module tb_ghost_motion_commit;
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] dir;
    logic       blk;
    logic [7:0] tc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ghost_motion_commit_if #(.WIDTH(640), .HEIGHT(480), .COLS(32), .ROWS(24)) gif ();

  ghost_motion_commit #(
    .TICK_DIV(8), .TILE_SIZE(20), .WIDTH(640), .HEIGHT(480),
    .COLS(32), .ROWS(24), .SPAWN_X(300), .SPAWN_Y(200)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (gif.slave)
  );

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference pacing: tick when divider hits 7 unfrozen, move_done 4 cycles later.
  logic [2:0] mdiv;
  logic [3:0] pipe;
  always @(posedge clk) begin
    if (reset) begin
      mdiv <= 3'd0;
      pipe <= 4'd0;
    end else begin
      pipe <= {pipe[2:0], (!gif.freeze && mdiv == 3'd7)};
      if (!gif.freeze) mdiv <= mdiv + 3'd1;
    end
  end

  // Monitor: timing of every cycle, payload of every move_done against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    chk("move_done_timing", 32'(gif.move_done), 32'(pipe[3]));
    if (gif.move_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_move_done: got pulse required none (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        chk("x", 32'(gif.x), 32'(e.x));
        chk("y", 32'(gif.y), 32'(e.y));
        chk("committed_dir", 32'(gif.committed_dir), 32'(e.dir));
        chk("blocked", 32'(gif.blocked), 32'(e.blk));
        chk("tick_count", 32'(gif.tick_count), 32'(e.tc));
      end
    end
  end

  task automatic wait_md(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gif.move_done !== 1'b1 && n < 40);
    if (gif.move_done !== 1'b1) chk("move_done_timeout", 32'(n), 32'(0));
  endtask

  task automatic wait_pipe(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pipe[k] !== 1'b1 && n < 40);
    if (pipe[k] !== 1'b1) chk("pipe_wait_timeout", 32'(n), 32'(0));
  endtask

  task automatic propose(input logic [9:0] nx, input logic [8:0] ny, input logic [1:0] nd,
                         input logic [9:0] ex, input logic [8:0] ey, input logic [1:0] ed,
                         input logic eb, input logic [7:0] et);
    int n;
    exp_t e;
    gif.next_x = nx;
    gif.next_y = ny;
    gif.ghost_direction = nd;
    e.x = ex; e.y = ey; e.dir = ed; e.blk = eb; e.tc = et;
    exp_q.push_back(e);
    wait_md(n);
  endtask

  initial begin
    int n;
    exp_t e;
    gif.freeze = 1'b0;
    gif.next_x = 10'd320;
    gif.next_y = 9'd200;
    gif.ghost_direction = DIR_RIGHT;
    gif.tilemap_walls = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_x", 32'(gif.x), 32'd300);
    chk("reset_y", 32'(gif.y), 32'd200);
    chk("reset_dir", 32'(gif.committed_dir), 32'(DIR_LEFT));
    chk("reset_blocked", 32'(gif.blocked), 32'd0);
    chk("reset_tick_count", 32'(gif.tick_count), 32'd0);
    chk("reset_move_done", 32'(gif.move_done), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_tick_hold_x", 32'(gif.x), 32'd300);

    // Wall at row 10, col 14 (index 334) blocks (280,200)
    gif.tilemap_walls[334] = 1'b1;
    propose(10'd280, 9'd200, DIR_LEFT, 10'd300, 9'd200, DIR_LEFT, 1'b1, 8'd0);
    gif.tilemap_walls = '0;
    propose(10'd280, 9'd200, DIR_LEFT, 10'd280, 9'd200, DIR_LEFT, 1'b0, 8'd1);
    propose(10'd280, 9'd200, DIR_RIGHT, 10'd280, 9'd200, DIR_RIGHT, 1'b0, 8'd2);
    propose(10'd0, 9'd200, DIR_LEFT, 10'd0, 9'd200, DIR_LEFT, 1'b0, 8'd3);
    propose(10'd1004, 9'd200, DIR_LEFT, 10'd0, 9'd200, DIR_LEFT, 1'b1, 8'd3);
    propose(10'd0, 9'd480, DIR_DOWN, 10'd0, 9'd200, DIR_LEFT, 1'b1, 8'd3);
    propose(10'd640, 9'd200, DIR_RIGHT, 10'd0, 9'd200, DIR_LEFT, 1'b1, 8'd3);
    gif.tilemap_walls[767] = 1'b1;
    propose(10'd639, 9'd479, DIR_DOWN, 10'd0, 9'd200, DIR_LEFT, 1'b1, 8'd3);
    gif.tilemap_walls = '0;
    propose(10'd620, 9'd460, DIR_DOWN, 10'd620, 9'd460, DIR_DOWN, 1'b0, 8'd4);

    // Freeze while idle, then resume from the held divider count
    gif.freeze = 1'b1;
    repeat (30) @(negedge clk);
    gif.freeze = 1'b0;
    propose(10'd600, 9'd460, DIR_LEFT, 10'd600, 9'd460, DIR_LEFT, 1'b0, 8'd5);

    // Freeze during an evaluation must not abort it
    gif.next_x = 10'd600;
    gif.next_y = 9'd440;
    gif.ghost_direction = DIR_UP;
    e.x = 10'd600; e.y = 9'd440; e.dir = DIR_UP; e.blk = 1'b0; e.tc = 8'd6;
    exp_q.push_back(e);
    wait_pipe(0);
    gif.freeze = 1'b1;
    wait_md(n);
    repeat (10) @(negedge clk);
    gif.freeze = 1'b0;

    // Reset in the LOOKUP cycle discards the move in flight
    gif.next_x = 10'd580;
    gif.next_y = 9'd440;
    gif.ghost_direction = DIR_LEFT;
    wait_pipe(1);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_x", 32'(gif.x), 32'd300);
    chk("midreset_y", 32'(gif.y), 32'd200);
    chk("midreset_move_done", 32'(gif.move_done), 32'd0);
    chk("midreset_tick_count", 32'(gif.tick_count), 32'd0);
    reset = 1'b0;
    e.x = 10'd580; e.y = 9'd440; e.dir = DIR_LEFT; e.blk = 1'b0; e.tc = 8'd1;
    exp_q.push_back(e);
    wait_md(n);
    chk("reset_resume_latency", 32'(n), 32'd11);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
